// File: rtl/axi_lite_master_bridge_pkg.sv
// Shared types for the core-to-AXI4-Lite master bridge: response codes,
// bridge state encoding and default sizing constants.
package lexington;

  localparam int DEFAULT_AXI_ADDR_WIDTH = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } bridge_state_e;

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Turns single-cycle core read/write requests into one AXI4-Lite transaction each,
// stalling the core via busy. Optional handshake watchdog: define AXI_TIMEOUT_EN.
module axi_lite_master_bridge
  import lexington::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_AXI_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strobe,
  output logic [31:0]           rd_data,
  output logic                  access_fault,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [2:0]            dbg_state_o
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid && ready; a raised valid and its payload hold until that edge.
  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_WRITE   = ST_WRITE;
  localparam logic [2:0] S_WR_RESP = ST_WR_RESP;
  localparam logic [2:0] S_RD_ADDR = ST_RD_ADDR;
  localparam logic [2:0] S_RD_DATA = ST_RD_DATA;
  localparam logic [2:0] S_DONE    = ST_DONE;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  fault_q, fault_d;

`ifdef AXI_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          hs_any;
  logic          active;

  assign hs_any = (awvalid_q && m_awready) || (wvalid_q && m_wready) ||
                  (arvalid_q && m_arready) || (m_bready && m_bvalid) ||
                  (m_rready && m_rvalid);
  assign active = (state_q != S_IDLE) && (state_q != S_DONE);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rd_data_d = rd_data_q;
    fault_d   = fault_q;
    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          addr_d    = addr;
          wdata_d   = wr_data;
          wstrb_d   = wr_strobe;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          fault_d   = 1'b0;
          state_d   = S_WRITE;
        end else if (rd_en) begin
          addr_d    = addr;
          arvalid_d = 1'b1;
          fault_d   = 1'b0;
          state_d   = S_RD_ADDR;
        end
      end
      S_WRITE: begin
        // AW and W retire independently; move on once neither is outstanding.
        awvalid_d = awvalid_q && !m_awready;
        wvalid_d  = wvalid_q && !m_wready;
        if (!awvalid_d && !wvalid_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (m_bvalid) begin
          fault_d = (m_bresp != RESP_OKAY);
          state_d = S_DONE;
        end
      end
      S_RD_ADDR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m_rvalid) begin
          rd_data_d = m_rdata;
          fault_d   = (m_rresp != RESP_OKAY);
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef AXI_TIMEOUT_EN
    tmo_d = tmo_q;
    if ((state_d != state_q) || hs_any) begin
      tmo_d = '0;
    end else if (active) begin
      if (tmo_q == TMO_LAST) begin
        state_d   = S_DONE;
        fault_d   = 1'b1;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        rd_data_d = '0;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rd_data_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rd_data_q <= rd_data_d;
      fault_q   <= fault_d;
    end
  end

`ifdef AXI_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  // Combinational so the core is stalled in the very cycle it raises a request.
  assign busy = ((state_q != S_IDLE) && (state_q != S_DONE)) ||
                ((state_q == S_IDLE) && (rd_en || wr_en));

  assign rd_data      = rd_data_q;
  assign access_fault = fault_q;
  assign m_awaddr     = addr_q;
  assign m_awprot     = 3'b000;
  assign m_awvalid    = awvalid_q;
  assign m_wdata      = wdata_q;
  assign m_wstrb      = wstrb_q;
  assign m_wvalid     = wvalid_q;
  assign m_bready     = (state_q == S_WR_RESP);
  assign m_araddr     = addr_q;
  assign m_arprot     = 3'b000;
  assign m_arvalid    = arvalid_q;
  assign m_rready     = (state_q == S_RD_DATA);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Self-checking bench for axi_lite_master_bridge: directed cases plus random
// transactions against a delay-configurable AXI4-Lite slave and a result scoreboard.
module tb_axi_lite_master_bridge;
  import lexington::*;

  localparam int AW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en, wr_en;
  logic [AW-1:0] addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strobe;
  logic [31:0]   rd_data;
  logic          access_fault, busy;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic          m_awvalid, m_awready, m_wvalid, m_wready;
  logic [31:0]   m_wdata, m_rdata;
  logic [3:0]    m_wstrb;
  logic [1:0]    m_bresp, m_rresp;
  logic          m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [2:0]    dbg_state;

  axi_lite_master_bridge #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
    .access_fault(access_fault), .busy(busy),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0]   exp_q[$];     // {access_fault, rd_data} at each completion
  logic [AW-1:0] exp_aw_q[$];
  logic [35:0]   exp_w_q[$];   // {strb, data}
  logic [AW-1:0] exp_ar_q[$];
  logic [31:0]   model_rd;

  int cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;
  bit          allow_drop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- slave model ----------------
  initial begin : slave
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    int n_aw, n_w, n_b, n_ar, n_r;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit prev_awv, prev_wv, prev_arv;
    logic [AW-1:0] prev_awaddr, prev_araddr;
    logic [35:0]   prev_w;
    m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
    m_bresp = 0; m_rresp = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        prev_awv = 0; prev_wv = 0; prev_arv = 0;
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
        continue;
      end
      if (aw_hs) begin
        n_aw++;
        if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
        else check("awaddr", prev_awaddr, exp_aw_q.pop_front());
      end
      if (w_hs) begin
        n_w++;
        if (exp_w_q.size() == 0) check("w_unexpected", 1, 0);
        else check("wstrb_wdata", prev_w, exp_w_q.pop_front());
      end
      if (ar_hs) begin
        n_ar++;
        if (exp_ar_q.size() == 0) check("ar_unexpected", 1, 0);
        else check("araddr", prev_araddr, exp_ar_q.pop_front());
      end
      if (b_hs) begin n_b++; m_bvalid = 0; b_wait = 0; end
      if (r_hs) begin n_r++; m_rvalid = 0; r_wait = 0; end
      if (prev_awv && !aw_hs) begin
        check("awvalid_held", m_awvalid, 1);
        check("awaddr_stable", m_awaddr, prev_awaddr);
      end
      if (prev_wv && !w_hs) begin
        check("wvalid_held", m_wvalid, 1);
        check("w_stable", {m_wstrb, m_wdata}, prev_w);
      end
      if (prev_arv && !ar_hs && !allow_drop) begin
        check("arvalid_held", m_arvalid, 1);
        check("araddr_stable", m_araddr, prev_araddr);
      end
      m_awready = m_awvalid && (aw_wait >= cfg_aw_d);
      aw_wait   = (m_awvalid && !m_awready) ? aw_wait + 1 : 0;
      m_wready  = m_wvalid && (w_wait >= cfg_w_d);
      w_wait    = (m_wvalid && !m_wready) ? w_wait + 1 : 0;
      m_arready = m_arvalid && (ar_wait >= cfg_ar_d);
      ar_wait   = (m_arvalid && !m_arready) ? ar_wait + 1 : 0;
      if (!m_bvalid && n_aw > n_b && n_w > n_b) begin
        if (b_wait >= cfg_b_d) begin m_bvalid = 1; m_bresp = cfg_bresp; end
        else b_wait++;
      end
      if (!m_rvalid && n_ar > n_r) begin
        if (r_wait >= cfg_r_d) begin m_rvalid = 1; m_rresp = cfg_rresp; m_rdata = cfg_rdata; end
        else r_wait++;
      end
      aw_hs = m_awvalid && m_awready;
      w_hs  = m_wvalid && m_wready;
      ar_hs = m_arvalid && m_arready;
      b_hs  = m_bvalid && m_bready;
      r_hs  = m_rvalid && m_rready;
      if (aw_hs) check("awprot", m_awprot, 0);
      if (ar_hs) check("arprot", m_arprot, 0);
      prev_awv = m_awvalid; prev_wv = m_wvalid; prev_arv = m_arvalid;
      prev_awaddr = m_awaddr; prev_araddr = m_araddr; prev_w = {m_wstrb, m_wdata};
    end
  end

  // ---------------- completion monitor ----------------
  initial begin : monitor
    logic prev_busy;
    logic [32:0] e;
    prev_busy = 0;
    forever begin
      @(negedge clk);
      #1;
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e[31:0]);
          check("access_fault", access_fault, e[32]);
        end
      end
      prev_busy = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic abort_reset(input string tag);
    exp_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    if (busy) exp_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    rst_n = 0; rd_en = 0; wr_en = 0;
    @(negedge clk);
    #1;
    check({tag, "_valids_low"}, {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_rd_data_zero"}, rd_data, 0);
    check({tag, "_fault_zero"}, access_fault, 0);
    model_rd = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_txn(input string tag, input bit do_rd, input bit do_wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int aw_d, input int w_d, input int b_d, input int ar_d,
                         input int r_d, input logic [1:0] bresp, input logic [1:0] rresp,
                         input logic [31:0] rdat);
    int exp_busy, cyc;
    bit saw_ar;
    cfg_aw_d = aw_d; cfg_w_d = w_d; cfg_b_d = b_d; cfg_ar_d = ar_d; cfg_r_d = r_d;
    cfg_bresp = bresp; cfg_rresp = rresp; cfg_rdata = rdat;
    if (do_wr) begin
      exp_aw_q.push_back(a);
      exp_w_q.push_back({s, d});
      exp_q.push_back({bresp != 2'b00, model_rd});
      exp_busy = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
    end else begin
      exp_ar_q.push_back(a);
      exp_q.push_back({rresp != 2'b00, rdat});
      model_rd = rdat;
      exp_busy = 3 + ar_d + r_d;
    end
    @(negedge clk);
    rd_en = do_rd; wr_en = do_wr; addr = a; wr_data = d; wr_strobe = s;
    cyc = 0; saw_ar = 0;
    #1;
    while (busy && cyc < 400) begin
      cyc++;
      saw_ar |= m_arvalid;
      @(negedge clk);
      #1;
    end
    check({tag, "_busy_cycles"}, cyc, exp_busy);
    if (do_rd && do_wr) check({tag, "_no_ar"}, saw_ar, 0);
    // The request stays up through the completion cycle, as a stalled core would.
    @(negedge clk);
    rd_en = 0; wr_en = 0;
    addr = $urandom(); wr_data = $urandom();
    if (cyc >= 400) abort_reset({tag, "_recover"});
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int cyc;
    rst_n = 0; rd_en = 0; wr_en = 0; addr = 0; wr_data = 0; wr_strobe = 0;
    allow_drop = 0; model_rd = 0;
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_d = 0; cfg_r_d = 0;
    cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_fault", access_fault, 0);
    check("reset_busy", busy, 0);
    check("reset_captured", {m_awaddr, m_wdata, m_wstrb}, 0);
    @(negedge clk);
    rst_n = 1;

    run_txn("wr_zero_wait", 0, 1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0,
            RESP_OKAY, RESP_OKAY, 0);
    run_txn("rd_delayed", 1, 0, 32'h0000_0020, 0, 0, 0, 0, 0, 3, 2,
            RESP_OKAY, RESP_OKAY, 32'h1234_5678);
    run_txn("wr_w_first", 0, 1, 32'h0000_0044, 32'hA5A5_0101, 4'h3, 2, 0, 1, 0, 0,
            RESP_OKAY, RESP_OKAY, 0);
    run_txn("wr_aw_first", 0, 1, 32'h0000_0048, 32'h0F0F_F0F0, 4'hC, 0, 3, 0, 0, 0,
            RESP_OKAY, RESP_OKAY, 0);
    run_txn("rd_slverr", 1, 0, 32'h0000_0030, 0, 0, 0, 0, 0, 1, 1,
            RESP_SLVERR, RESP_SLVERR, 32'hDEAD_BEEF);
    run_txn("rd_okay", 1, 0, 32'h0000_0034, 0, 0, 0, 0, 0, 0, 0,
            RESP_OKAY, RESP_OKAY, 32'h0BAD_CAFE);
    run_txn("rd_wr_both", 1, 1, 32'h0000_0050, 32'h1111_2222, 4'h1, 1, 1, 0, 0, 0,
            RESP_OKAY, RESP_OKAY, 32'h9999_9999);
    run_txn("wr_decerr", 0, 1, 32'h0000_0054, 32'h3333_4444, 4'hF, 0, 0, 2, 0, 0,
            RESP_DECERR, RESP_OKAY, 0);
    run_txn("wr_okay_after_err", 0, 1, 32'h0000_0058, 32'h5555_6666, 4'hF, 1, 0, 0, 0, 0,
            RESP_OKAY, RESP_OKAY, 0);

    // Reset while the bridge waits in the read-data phase.
    cfg_ar_d = 0; cfg_r_d = 50; cfg_rresp = RESP_OKAY; cfg_rdata = 32'h7777_7777;
    exp_ar_q.push_back(32'h0000_0060);
    @(negedge clk);
    rd_en = 1; addr = 32'h0000_0060;
    cyc = 0;
    #1;
    while (!m_rready && cyc < 20) begin cyc++; @(negedge clk); #1; end
    check("reached_rd_data", m_rready, 1);
    abort_reset("rst_mid_read");

    // Slave that never accepts the read address.
    cfg_ar_d = 100000;
    exp_ar_q.push_back(32'h0000_0070);
`ifdef AXI_TIMEOUT_EN
    allow_drop = 1;
    exp_q.push_back({1'b1, 32'h0});
    model_rd = 0;
    @(negedge clk);
    rd_en = 1; addr = 32'h0000_0070;
    cyc = 0;
    #1;
    while (busy && cyc < 400) begin cyc++; @(negedge clk); #1; end
    check("timeout_busy_cycles", cyc, 1 + TMO);
    check("timeout_arvalid_dropped", m_arvalid, 0);
    @(negedge clk);
    rd_en = 0;
    exp_ar_q.delete();
    allow_drop = 0;
`else
    @(negedge clk);
    rd_en = 1; addr = 32'h0000_0070;
    repeat (300) @(negedge clk);
    #1;
    check("stall_busy_high", busy, 1);
    check("stall_arvalid_high", m_arvalid, 1);
    check("stall_araddr", m_araddr, 32'h0000_0070);
    abort_reset("stall_abort");
`endif

    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 2);
      run_txn("rand", op != 1, op != 0, $urandom(), $urandom(), 4'($urandom_range(0, 15)),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom());
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_aw_drained", exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
